// File: rtl/oq_sram_responder_pkg.sv
// ---------------------------------------------------------------------------
// oq_sram_responder_pkg
//   Shared definitions for the output-queue SRAM responder: default datapath
//   and SRAM timing parameters, plus the round-robin pointer type used by the
//   write/read arbiter.
// ---------------------------------------------------------------------------
package oq_sram_responder_pkg;

  // Default datapath geometry. One SRAM word holds {ctrl, data}.
  localparam int DEF_DATA_WIDTH      = 64;
  localparam int DEF_CTRL_WIDTH      = DEF_DATA_WIDTH / 8;
  localparam int DEF_SRAM_WORD_WIDTH = DEF_DATA_WIDTH + DEF_CTRL_WIDTH;
  localparam int DEF_SRAM_ADDR_WIDTH = 19;

  // Default ZBT pin timing, counted from the cycle the address is on the pins.
  localparam int DEF_SRAM_RD_LATENCY = 2;
  localparam int DEF_SRAM_WR_DELAY   = 2;

  // Which port wins when both requesters are eligible in the same cycle.
  typedef enum logic {
    RR_WRITE = 1'b0,
    RR_READ  = 1'b1
  } rr_port_e;

  // After a grant the priority moves to the port that was not served.
  function automatic rr_port_e rr_other(input rr_port_e served);
    return (served == RR_WRITE) ? RR_READ : RR_WRITE;
  endfunction

endpackage

// File: rtl/oq_sram_delay_line.sv
// ---------------------------------------------------------------------------
// oq_sram_delay_line
//   Parameterised {valid, data} shift register. A token entering on in_valid
//   appears on out_valid exactly DEPTH cycles later with its data. Stages only
//   load data when the token ahead of them is valid, so out_data holds the
//   last delivered word between tokens.
//
// Ports
//   clk        in   clock
//   reset      in   synchronous, active-high; clears every stage
//   in_valid   in   token entering stage 0
//   in_data    in   data travelling with the token
//   out_valid  out  token leaving the last stage
//   out_data   out  data of the last stage
// ---------------------------------------------------------------------------
module oq_sram_delay_line
  import oq_sram_responder_pkg::*;
#(
  parameter int DEPTH = DEF_SRAM_WR_DELAY,
  parameter int WIDTH = DEF_SRAM_WORD_WIDTH
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_data,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_data
);

  logic             valid_q [DEPTH];
  logic             valid_d [DEPTH];
  logic [WIDTH-1:0] data_q  [DEPTH];
  logic [WIDTH-1:0] data_d  [DEPTH];

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_stage
      if (gi == 0) begin : g_head
        assign valid_d[gi] = in_valid;
        assign data_d[gi]  = in_valid ? in_data : data_q[gi];
      end else begin : g_tail
        assign valid_d[gi] = valid_q[gi-1];
        assign data_d[gi]  = valid_q[gi-1] ? data_q[gi-1] : data_q[gi];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          valid_q[gi] <= 1'b0;
          data_q[gi]  <= '0;
        end else begin
          valid_q[gi] <= valid_d[gi];
          data_q[gi]  <= data_d[gi];
        end
      end
    end
  endgenerate

  assign out_valid = valid_q[DEPTH-1];
  assign out_data  = data_q[DEPTH-1];

endmodule

// File: rtl/oq_sram_responder.sv
// ---------------------------------------------------------------------------
// oq_sram_responder
//   Responder end of the output-queue wr_0/rd_0 SRAM request protocol. Picks
//   at most one request per cycle (round-robin when both are eligible), drives
//   a pipelined ZBT SRAM from registered pins, and returns read words in
//   acceptance order a fixed number of cycles after the read ack.
//
// Ports
//   clk, reset                 single clock, synchronous active-high reset
//   wr_0_req/addr/data         write request, held until wr_0_ack
//   wr_0_ack                   one-cycle pulse, write captured
//   rd_0_req/addr              read request, held until rd_0_ack
//   rd_0_ack                   one-cycle pulse, read captured
//   rd_0_data/rd_0_vld         read word, one pulse per accepted read
//   sram_addr/sram_we          registered SRAM address and write strobe
//   sram_wr_data/sram_tri_en   registered write data and pad output enable
//   sram_rd_data               data from the SRAM pins
//
// Timing, for a grant decided in cycle T:
//   T+1                 ack pulse, sram_addr/sram_we on the pins
//   T+1+WR_DELAY        write data on the pins with tri_en, one cycle
//   T+1+RD_LATENCY      read data on the pins, sampled at the end of it
//   T+2+RD_LATENCY      rd_0_vld / rd_0_data
// ---------------------------------------------------------------------------
module oq_sram_responder
  import oq_sram_responder_pkg::*;
#(
  parameter int DATA_WIDTH      = DEF_DATA_WIDTH,
  parameter int CTRL_WIDTH      = DATA_WIDTH / 8,
  parameter int SRAM_ADDR_WIDTH = DEF_SRAM_ADDR_WIDTH,
  parameter int SRAM_RD_LATENCY = DEF_SRAM_RD_LATENCY,
  parameter int SRAM_WR_DELAY   = DEF_SRAM_WR_DELAY
) (
  input  logic                             clk,
  input  logic                             reset,
  // write request port
  input  logic                             wr_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0]       wr_0_addr,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] wr_0_data,
  output logic                             wr_0_ack,
  // read request port
  input  logic                             rd_0_req,
  input  logic [SRAM_ADDR_WIDTH-1:0]       rd_0_addr,
  output logic                             rd_0_ack,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0] rd_0_data,
  output logic                             rd_0_vld,
  // SRAM pins
  output logic [SRAM_ADDR_WIDTH-1:0]       sram_addr,
  output logic                             sram_we,
  output logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_wr_data,
  output logic                             sram_tri_en,
  input  logic [DATA_WIDTH+CTRL_WIDTH-1:0] sram_rd_data
);

  localparam int WORD_W    = DATA_WIDTH + CTRL_WIDTH;
  // The read token must line up with the cycle the SRAM drives the data,
  // i.e. RD_LATENCY cycles after the address cycle, which is itself one
  // cycle after the grant.
  localparam int RD_STAGES = SRAM_RD_LATENCY + 1;

  // -------------------------------------------------------------------------
  // Arbiter state and registered outputs
  // -------------------------------------------------------------------------
  rr_port_e                   rr_q, rr_d;
  logic                       wr_ack_q, wr_ack_d;
  logic                       rd_ack_q, rd_ack_d;
  logic [SRAM_ADDR_WIDTH-1:0] sram_addr_q, sram_addr_d;
  logic                       sram_we_q, sram_we_d;
  logic [WORD_W-1:0]          sram_wr_data_q, sram_wr_data_d;
  logic                       sram_tri_en_q, sram_tri_en_d;

  logic                       wr_elig, rd_elig;
  logic                       grant_wr, grant_rd;

  logic                       wr_dl_valid;
  logic [WORD_W-1:0]          wr_dl_data;

  logic                       rd_tok_q [RD_STAGES];
  logic                       rd_tok_d [RD_STAGES];

  // A requester keeps req high through the ack cycle, so a port acked in the
  // previous cycle is still showing its old request; it must not be granted
  // again until the requester has had a chance to drop or change it.
  assign wr_elig = wr_0_req & ~wr_ack_q;
  assign rd_elig = rd_0_req & ~rd_ack_q;

  always_comb begin
    grant_wr       = 1'b0;
    grant_rd       = 1'b0;
    rr_d           = rr_q;
    sram_addr_d    = sram_addr_q;
    sram_wr_data_d = sram_wr_data_q;

    if (wr_elig && (!rd_elig || rr_q == RR_WRITE)) begin
      grant_wr = 1'b1;
    end else if (rd_elig) begin
      grant_rd = 1'b1;
    end

    if (grant_wr) begin
      rr_d        = rr_other(RR_WRITE);
      sram_addr_d = wr_0_addr;
    end else if (grant_rd) begin
      rr_d        = rr_other(RR_READ);
      sram_addr_d = rd_0_addr;
    end

    wr_ack_d  = grant_wr;
    rd_ack_d  = grant_rd;
    sram_we_d = grant_wr;

    // Write data reaches the pins one register after leaving the delay line;
    // the pins hold the last word while the output enable is off.
    sram_tri_en_d = wr_dl_valid;
    if (wr_dl_valid) begin
      sram_wr_data_d = wr_dl_data;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      rr_q           <= RR_WRITE;
      wr_ack_q       <= 1'b0;
      rd_ack_q       <= 1'b0;
      sram_addr_q    <= '0;
      sram_we_q      <= 1'b0;
      sram_wr_data_q <= '0;
      sram_tri_en_q  <= 1'b0;
    end else begin
      rr_q           <= rr_d;
      wr_ack_q       <= wr_ack_d;
      rd_ack_q       <= rd_ack_d;
      sram_addr_q    <= sram_addr_d;
      sram_we_q      <= sram_we_d;
      sram_wr_data_q <= sram_wr_data_d;
      sram_tri_en_q  <= sram_tri_en_d;
    end
  end

  // -------------------------------------------------------------------------
  // Write-data path: the word is captured at grant and released WR_DELAY
  // cycles later into the pin register.
  // -------------------------------------------------------------------------
  oq_sram_delay_line #(
    .DEPTH (SRAM_WR_DELAY),
    .WIDTH (WORD_W)
  ) u_wr_delay (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (grant_wr),
    .in_data   (wr_0_data),
    .out_valid (wr_dl_valid),
    .out_data  (wr_dl_data)
  );

  // -------------------------------------------------------------------------
  // Read-return path: a valid-only token marks the cycle in which the SRAM is
  // driving the requested word; the return stage captures the pins on it.
  // -------------------------------------------------------------------------
  genvar gi;
  generate
    for (gi = 0; gi < RD_STAGES; gi++) begin : g_rd_tok
      if (gi == 0) begin : g_head
        assign rd_tok_d[gi] = grant_rd;
      end else begin : g_tail
        assign rd_tok_d[gi] = rd_tok_q[gi-1];
      end

      always_ff @(posedge clk) begin
        if (reset) begin
          rd_tok_q[gi] <= 1'b0;
        end else begin
          rd_tok_q[gi] <= rd_tok_d[gi];
        end
      end
    end
  endgenerate

  oq_sram_delay_line #(
    .DEPTH (1),
    .WIDTH (WORD_W)
  ) u_rd_return (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (rd_tok_q[RD_STAGES-1]),
    .in_data   (sram_rd_data),
    .out_valid (rd_0_vld),
    .out_data  (rd_0_data)
  );

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  assign wr_0_ack     = wr_ack_q;
  assign rd_0_ack     = rd_ack_q;
  assign sram_addr    = sram_addr_q;
  assign sram_we      = sram_we_q;
  assign sram_wr_data = sram_wr_data_q;
  assign sram_tri_en  = sram_tri_en_q;

endmodule

// File: tb/tb_oq_sram_responder.sv
// ---------------------------------------------------------------------------
// tb_oq_sram_responder
//   Directed bench for oq_sram_responder with a behavioural ZBT SRAM model.
//   Stimulus pushes expected addresses/words into scoreboard queues; a
//   monitor on the falling edge pops and compares as the DUT presents acks,
//   write data on the pins and read returns.
// ---------------------------------------------------------------------------
module tb_oq_sram_responder;

  localparam int W  = 72;
  localparam int AW = 19;

  logic          clk;
  logic          reset;
  logic          wr_0_req;
  logic [AW-1:0] wr_0_addr;
  logic [W-1:0]  wr_0_data;
  logic          wr_0_ack;
  logic          rd_0_req;
  logic [AW-1:0] rd_0_addr;
  logic          rd_0_ack;
  logic [W-1:0]  rd_0_data;
  logic          rd_0_vld;
  logic [AW-1:0] sram_addr;
  logic          sram_we;
  logic [W-1:0]  sram_wr_data;
  logic          sram_tri_en;
  logic [W-1:0]  sram_rd_data;

  oq_sram_responder dut (
    .clk          (clk),
    .reset        (reset),
    .wr_0_req     (wr_0_req),
    .wr_0_addr    (wr_0_addr),
    .wr_0_data    (wr_0_data),
    .wr_0_ack     (wr_0_ack),
    .rd_0_req     (rd_0_req),
    .rd_0_addr    (rd_0_addr),
    .rd_0_ack     (rd_0_ack),
    .rd_0_data    (rd_0_data),
    .rd_0_vld     (rd_0_vld),
    .sram_addr    (sram_addr),
    .sram_we      (sram_we),
    .sram_wr_data (sram_wr_data),
    .sram_tri_en  (sram_tri_en),
    .sram_rd_data (sram_rd_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests_run = 0;
  int tests_failed = 0;
  int vld_count = 0;

  // scoreboard queues
  logic [AW-1:0] wa_q[$];
  logic [W-1:0]  wd_q[$];
  logic [AW-1:0] ra_q[$];
  logic [W-1:0]  rd_q[$];

  // stimulus lists consumed by run_ops
  logic [AW-1:0] wl_a[$];
  logic [W-1:0]  wl_d[$];
  logic [AW-1:0] rl_a[$];
  bit            seq[$];

  // reference contents (bench view) and SRAM model contents (pin view)
  logic [W-1:0] ref_mem [logic [AW-1:0]];
  logic [W-1:0] mem     [logic [AW-1:0]];

  function automatic logic [W-1:0] def_word(input logic [AW-1:0] a);
    return {8'hC3, 45'h0, a};
  endfunction

  function automatic logic [W-1:0] ref_lookup(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : def_word(a);
  endfunction

  task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    tests_run++;
    if (act !== exp) begin
      tests_failed++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ZBT model: address cycle C, write data on pins at C+2, read data driven
  // during C+2. The write is applied before the lookup so a read issued the
  // cycle after a write to the same address returns the new word.
  initial begin : sram_model
    logic [AW-1:0] ra1, wa1, wa2;
    ra1 = '0; wa1 = '0; wa2 = '0;
    sram_rd_data = '0;
    forever begin
      @(posedge clk);
      if (sram_tri_en) mem[wa2] = sram_wr_data;
      sram_rd_data <= mem.exists(ra1) ? mem[ra1] : def_word(ra1);
      wa2 = wa1;
      wa1 = sram_addr;
      ra1 = sram_addr;
    end
  end

  // Monitor: pops and compares whenever the DUT presents something.
  initial begin : monitor
    logic [1:0] wr_h;
    logic [2:0] rd_h;
    wr_h = '0; rd_h = '0;
    forever begin
      @(negedge clk);
      if (reset) begin
        wa_q.delete(); wd_q.delete(); ra_q.delete(); rd_q.delete();
        wr_h = '0; rd_h = '0;
        continue;
      end
      if (wr_0_ack) begin
        check("wr_ack_we", W'(sram_we), W'(1'b1));
        if (wa_q.size() > 0) check("wr_addr", W'(sram_addr), W'(wa_q.pop_front()));
        else check("wr_ack_unexpected", W'(1'b1), W'(1'b0));
      end
      if (rd_0_ack) begin
        check("rd_ack_we", W'(sram_we), W'(1'b0));
        if (ra_q.size() > 0) check("rd_addr", W'(sram_addr), W'(ra_q.pop_front()));
        else check("rd_ack_unexpected", W'(1'b1), W'(1'b0));
      end
      if (sram_tri_en || wr_h[1]) begin
        check("tri_en_timing", W'(sram_tri_en), W'(wr_h[1]));
        if (sram_tri_en) begin
          if (wd_q.size() > 0) check("wr_data", sram_wr_data, wd_q.pop_front());
          else check("tri_en_unexpected", W'(1'b1), W'(1'b0));
        end
      end
      if (rd_0_vld || rd_h[2]) begin
        check("vld_timing", W'(rd_0_vld), W'(rd_h[2]));
        if (rd_0_vld) begin
          vld_count++;
          if (rd_q.size() > 0) check("rd_data", rd_0_data, rd_q.pop_front());
          else check("vld_unexpected", W'(1'b1), W'(1'b0));
        end
      end
      wr_h = {wr_h[0], wr_0_ack};
      rd_h = {rd_h[1:0], rd_0_ack};
    end
  end

  task automatic present_write();
    logic [AW-1:0] a;
    logic [W-1:0]  d;
    a = wl_a.pop_front();
    d = wl_d.pop_front();
    wr_0_addr = a; wr_0_data = d; wr_0_req = 1'b1;
    wa_q.push_back(a); wd_q.push_back(d);
    ref_mem[a] = d;
  endtask

  task automatic present_read();
    logic [AW-1:0] a;
    a = rl_a.pop_front();
    rd_0_addr = a; rd_0_req = 1'b1;
    ra_q.push_back(a); rd_q.push_back(ref_lookup(a));
  endtask

  // Holds requests high, moving to the next item on each ack, until both
  // lists are consumed. Returns the number of cycles until the last ack.
  task automatic run_ops(input int max_cycles, output int cycles);
    bit wp, rp;
    cycles = 0;
    seq.delete();
    wp = (wl_a.size() > 0);
    rp = (rl_a.size() > 0);
    if (wp) present_write();
    if (rp) present_read();
    while (wp || rp) begin
      @(posedge clk); #1;
      cycles++;
      if (wr_0_ack && wp) begin
        seq.push_back(1'b0);
        if (wl_a.size() > 0) present_write();
        else begin wr_0_req = 1'b0; wp = 1'b0; end
      end
      if (rd_0_ack && rp) begin
        seq.push_back(1'b1);
        if (rl_a.size() > 0) present_read();
        else begin rd_0_req = 1'b0; rp = 1'b0; end
      end
      if ((wp || rp) && cycles >= max_cycles) begin
        check("ack_timeout", W'(1'b1), W'(1'b0));
        wr_0_req = 1'b0; rd_0_req = 1'b0;
        wl_a.delete(); wl_d.delete(); rl_a.delete();
        wp = 1'b0; rp = 1'b0;
      end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : stimulus
    int cyc, v0, bad, tri_seen;
    reset = 1'b1;
    wr_0_req = 1'b0; wr_0_addr = '0; wr_0_data = '0;
    rd_0_req = 1'b0; rd_0_addr = '0;
    mem[19'h7FFFF]     = 72'h55_5555_5555_5555_5555;
    ref_mem[19'h7FFFF] = 72'h55_5555_5555_5555_5555;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;

    // 1: idle after reset
    tri_seen = 0;
    repeat (10) begin
      @(negedge clk);
      if (sram_tri_en) tri_seen++;
    end
    check("idle_wr_ack", W'(wr_0_ack), '0);
    check("idle_rd_ack", W'(rd_0_ack), '0);
    check("idle_rd_vld", W'(rd_0_vld), '0);
    check("idle_rd_data", rd_0_data, '0);
    check("idle_sram_we", W'(sram_we), '0);
    check("idle_sram_addr", W'(sram_addr), '0);
    check("idle_sram_wr_data", sram_wr_data, '0);
    check("idle_tri_en_seen", W'(tri_seen), '0);
    @(posedge clk); #1;

    // 2: single write
    wl_a.push_back(19'h00010); wl_d.push_back(72'h0A_DEADBEEF_CAFEF00D);
    run_ops(10, cyc);
    check("single_wr_ack_cycles", W'(cyc), W'(1));
    repeat (8) @(posedge clk); #1;

    // 3: single read of a preloaded word
    v0 = vld_count;
    rl_a.push_back(19'h7FFFF);
    run_ops(10, cyc);
    check("single_rd_ack_cycles", W'(cyc), W'(1));
    repeat (8) @(posedge clk); #1;
    check("single_rd_vlds", W'(vld_count - v0), W'(1));

    // 4: both held, each read follows the write to the same address
    v0 = vld_count;
    for (int i = 0; i < 10; i++) begin
      wl_a.push_back(AW'(19'h00100 + i));
      wl_d.push_back({8'(8'h40 + i), 32'h1234_5678, 32'(i * 3 + 1)});
      rl_a.push_back(AW'(19'h00100 + i));
    end
    run_ops(60, cyc);
    check("alt_cycles", W'(cyc), W'(20));
    check("alt_grants", W'(seq.size()), W'(20));
    for (int k = 0; k < seq.size(); k++) check($sformatf("alt_order_%0d", k), W'(seq[k]), W'(k % 2));
    repeat (10) @(posedge clk); #1;
    check("alt_vlds", W'(vld_count - v0), W'(10));

    // 5: reads only, held request
    v0 = vld_count;
    for (int i = 0; i < 5; i++) rl_a.push_back(AW'(19'h00300 + 7 * i));
    run_ops(40, cyc);
    check("rd_only_cycles", W'(cyc), W'(9));
    repeat (10) @(posedge clk); #1;
    check("rd_only_vlds", W'(vld_count - v0), W'(5));

    // 6: reset with reads and a write still in flight
    wl_a.push_back(19'h00400); wl_d.push_back(72'h11_1111_1111_1111_1111);
    wl_a.push_back(19'h00401); wl_d.push_back(72'h22_2222_2222_2222_2222);
    rl_a.push_back(19'h00402);
    rl_a.push_back(19'h00403);
    run_ops(20, cyc);
    check("pre_reset_cycles", W'(cyc), W'(4));
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    bad = 0;
    repeat (8) begin
      @(negedge clk);
      if (rd_0_vld || sram_tri_en) bad++;
    end
    check("post_reset_quiet", W'(bad), '0);
    @(posedge clk); #1;
    v0 = vld_count;
    rl_a.push_back(19'h00010);
    run_ops(10, cyc);
    check("post_reset_rd_ack_cycles", W'(cyc), W'(1));
    repeat (8) @(posedge clk); #1;
    check("post_reset_rd_vlds", W'(vld_count - v0), W'(1));

    check("wr_queue_drained", W'(wd_q.size()), '0);
    check("rd_queue_drained", W'(rd_q.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
